// File: rtl/vmem_pkg.sv
// Package: vmem_pkg
// Shared constants and types for the text-mode video memory.
//  - ASCII codes that the cursor logic treats specially.
//  - Character drawn over the cursor cell while the blink phase is on.
//  - Controller state encoding.
package vmem_pkg;

  localparam logic [7:0] KEY_ENTER = 8'd10;
  localparam logic [7:0] KEY_BS    = 8'd8;
  localparam logic [7:0] CURSOR_CH = 8'h5F;

  typedef enum logic [1:0] {
    CLR_ALL,
    IDLE,
    CLR_ROW
  } state_e;

endpackage

// File: rtl/text_vmem_ram.sv
// Module: text_vmem_ram
// Character store: DEPTH x 8 bits, one synchronous write port and one
// asynchronous (combinational) read port for the renderer.
// Ports:
//  clk    in   1   write clock
//  we     in   1   write enable
//  waddr  in   AW  write address
//  wdata  in   8   write data
//  raddr  in   AW  read address
//  rdata  out  8   read data, combinational; 0 for addresses beyond DEPTH
module text_vmem_ram #(
  parameter int DEPTH = 2100,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array has no reset branch; a reset on storage would turn the
  // RAM into thousands of flops. Contents are zeroed by the controller's
  // clear sweep instead.
  always_ff @(posedge clk) begin
    if (we && (waddr < AW'(DEPTH))) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range renderer coordinates read as blank rather than X.
  assign rdata = (raddr < AW'(DEPTH)) ? mem[raddr] : 8'h00;

endmodule

// File: rtl/text_vmem.sv
// Module: text_vmem
// Text-mode video memory between the keyboard decoder and the character
// renderer. Holds one ASCII code per cell, tracks a cursor, handles ENTER,
// BACKSPACE and scrolling through a circular top-row pointer, and serves
// combinational lookups to the font-ROM path.
// Optional feature macro: CURSOR_BLINK_EN (blinking '_' over the cursor cell).
// Ports:
//  clk        in   1        system clock
//  reset      in   1        asynchronous, active-low reset
//  key_in     in   8        ASCII code from the keyboard decoder
//  key_valid  in   1        key_in valid; transfer on key_valid & key_ready
//  key_ready  out  1        high only while idle
//  x, y       in   XW, YW   cell being rendered (y = 0 is top of screen)
//  v_addr     in   VADDR_W  VGA vertical pixel line
//  ascii_out  out  8        character at (x, y), combinational
//  row        out  4        glyph line = v_addr - y*FONT_H (low 4 bits)
//  cur_x      out  XW       cursor column
//  cur_y      out  YW       cursor screen row
module text_vmem
  import vmem_pkg::*;
#(
  parameter  int COLS      = 70,
  parameter  int ROWS      = 30,
  parameter  int FONT_H    = 16,
  parameter  int VADDR_W   = 10,
  parameter  int BLINK_CYC = 25000000,
  localparam int XW        = $clog2(COLS),
  localparam int YW        = $clog2(ROWS),
  localparam int AW        = $clog2(COLS * ROWS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         key_in,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [XW-1:0]      x,
  input  logic [YW-1:0]      y,
  input  logic [VADDR_W-1:0] v_addr,
  output logic [7:0]         ascii_out,
  output logic [3:0]         row,
  output logic [XW-1:0]      cur_x,
  output logic [YW-1:0]      cur_y
);

  localparam int CELLS = COLS * ROWS;

  if (BLINK_CYC < 1) begin : g_bad_blink_cyc
    $error("BLINK_CYC must be at least 1");
  end

  state_e        state_q, state_d;
  logic [XW-1:0] cur_x_q, cur_x_d;
  logic [YW-1:0] cur_y_q, cur_y_d;
  logic [YW-1:0] top_q, top_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [7:0]    ram_rdata;
  logic          newline;

  // Screen (cx, cy) -> physical cell. The physical row index rotates with
  // the top pointer; y + top is below 2*ROWS, so one compare-subtract
  // replaces the modulo.
  function automatic logic [AW-1:0] phys_addr(input logic [XW-1:0] cx,
                                              input logic [YW-1:0] cy,
                                              input logic [YW-1:0] top);
    logic [YW:0] r;
    r = {1'b0, cy} + {1'b0, top};
    if (r >= (YW+1)'(ROWS)) begin
      r = r - (YW+1)'(ROWS);
    end
    return AW'(r) * AW'(COLS) + AW'(cx);
  endfunction

  assign key_ready = (state_q == IDLE);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    top_d     = top_q;
    clr_cnt_d = clr_cnt_q;
    ram_we    = 1'b0;
    ram_waddr = phys_addr(cur_x_q, cur_y_q, top_q);
    ram_wdata = 8'h00;
    newline   = 1'b0;

    case (state_q)
      CLR_ALL: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        if (clr_cnt_q == AW'(CELLS - 1)) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      IDLE: begin
        if (key_valid) begin
          if (key_in == KEY_ENTER) begin
            newline = 1'b1;
          end else if (key_in == KEY_BS) begin
            if (cur_x_q != '0) begin
              cur_x_d   = cur_x_q - 1'b1;
              ram_we    = 1'b1;
              ram_waddr = phys_addr(cur_x_q - 1'b1, cur_y_q, top_q);
            end else if (cur_y_q != '0) begin
              cur_x_d   = XW'(COLS - 1);
              cur_y_d   = cur_y_q - 1'b1;
              ram_we    = 1'b1;
              ram_waddr = phys_addr(XW'(COLS - 1), cur_y_q - 1'b1, top_q);
            end
          end else begin
            ram_we    = 1'b1;
            ram_wdata = key_in;
            if (cur_x_q == XW'(COLS - 1)) begin
              newline = 1'b1;
            end else begin
              cur_x_d = cur_x_q + 1'b1;
            end
          end
        end

        // A wrapped printable has already been written above at the old
        // cursor; the scroll below only moves the top pointer.
        if (newline) begin
          cur_x_d = '0;
          if (cur_y_q != YW'(ROWS - 1)) begin
            cur_y_d = cur_y_q + 1'b1;
          end else begin
            top_d     = (top_q == YW'(ROWS - 1)) ? '0 : top_q + 1'b1;
            clr_cnt_d = '0;
            state_d   = CLR_ROW;
          end
        end
      end

      CLR_ROW: begin
        // With the new top pointer the bottom screen row maps onto the
        // physical row that used to be on top.
        ram_we    = 1'b1;
        ram_waddr = phys_addr(clr_cnt_q[XW-1:0], YW'(ROWS - 1), top_q);
        if (clr_cnt_q == AW'(COLS - 1)) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = CLR_ALL;
        clr_cnt_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLR_ALL;
      cur_x_q   <= '0;
      cur_y_q   <= '0;
      top_q     <= '0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_x_q   <= cur_x_d;
      cur_y_q   <= cur_y_d;
      top_q     <= top_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign ram_raddr = phys_addr(x, y, top_q);

  text_vmem_ram #(
    .DEPTH (CELLS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

`ifdef CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_CYC + 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_d     = blink_q;
    if (blink_cnt_q == BW'(BLINK_CYC - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign ascii_out = (blink_q && (x == cur_x_q) && (y == cur_y_q)) ? CURSOR_CH
                                                                   : ram_rdata;
`else
  assign ascii_out = ram_rdata;
`endif

  // Only the low four bits of the difference matter, and those depend only
  // on the low bits of the operands.
  assign row = 4'(v_addr - VADDR_W'(32'(y) * FONT_H));

  assign cur_x = cur_x_q;
  assign cur_y = cur_y_q;

endmodule

// File: tb/tb_text_vmem.sv
// Testbench: tb_text_vmem
// Drives text_vmem with directed and random keystrokes and compares the
// visible screen, cursor and glyph-row outputs against a screen-coordinate
// model in which scrolling is a plain shift of rows.
module tb_text_vmem;

  localparam int COLS    = 70;
  localparam int ROWS    = 30;
  localparam int FONT_H  = 16;
  localparam int VADDR_W = 10;
  localparam int BLINK   = 4;
  localparam int XW      = $clog2(COLS);
  localparam int YW      = $clog2(ROWS);
  localparam int LIMIT   = 5000;

  logic               clk = 1'b0;
  logic               reset;
  logic [7:0]         key_in;
  logic               key_valid;
  logic               key_ready;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [VADDR_W-1:0] v_addr;
  logic [7:0]         ascii_out;
  logic [3:0]         row;
  logic [XW-1:0]      cur_x;
  logic [YW-1:0]      cur_y;

  int n_cmp = 0;
  int n_err = 0;

  // Reference screen in screen coordinates plus cursor.
  logic [7:0] scr [ROWS][COLS];
  int mx, my;

  text_vmem #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .FONT_H    (FONT_H),
    .VADDR_W   (VADDR_W),
    .BLINK_CYC (BLINK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .x         (x),
    .y         (y),
    .v_addr    (v_addr),
    .ascii_out (ascii_out),
    .row       (row),
    .cur_x     (cur_x),
    .cur_y     (cur_y)
  );

  always #5 clk = ~clk;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 8'h00;
    mx = 0;
    my = 0;
  endtask

  task automatic model_newline();
    mx = 0;
    if (my < ROWS - 1) begin
      my++;
    end else begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = 8'h00;
    end
  endtask

  task automatic model_key(input logic [7:0] k);
    if (k == 8'd10) begin
      model_newline();
    end else if (k == 8'd8) begin
      if (mx > 0) begin
        mx--;
        scr[my][mx] = 8'h00;
      end else if (my > 0) begin
        my--;
        mx = COLS - 1;
        scr[my][mx] = 8'h00;
      end
    end else begin
      scr[my][mx] = k;
      if (mx == COLS - 1) model_newline();
      else mx++;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check_screen(input string name);
    int bad, bx, by;
    logic [7:0] bgot, bexp;
    bad = 0; bx = 0; by = 0; bgot = 0; bexp = 0;
    for (int yy = 0; yy < ROWS; yy++) begin
      for (int xx = 0; xx < COLS; xx++) begin
`ifdef CURSOR_BLINK_EN
        if (xx == mx && yy == my) continue;
`endif
        x = XW'(xx);
        y = YW'(yy);
        #1;
        if (ascii_out !== scr[yy][xx]) begin
          if (bad == 0) begin
            bx = xx; by = yy; bgot = ascii_out; bexp = scr[yy][xx];
          end
          bad++;
        end
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s screen: %0d cells differ, first (%0d,%0d) got %02h want %02h",
               name, bad, bx, by, bgot, bexp);
    end
  endtask

  task automatic check_cursor(input string name, input int ex, input int ey);
    n_cmp++;
    if (cur_x !== XW'(ex) || cur_y !== YW'(ey)) begin
      n_err++;
      $display("FAIL %s cursor: got (%0d,%0d) want (%0d,%0d)", name, cur_x, cur_y, ex, ey);
    end
  endtask

  task automatic read_cell(input int cx, input int cy, output logic [7:0] v);
    x = XW'(cx);
    y = YW'(cy);
    #1;
    v = ascii_out;
  endtask

  // Present a key, hold until accepted, return cycles key_ready stayed low.
  task automatic send_key(input logic [7:0] k, output int busy);
    int n;
    @(negedge clk);
    key_in = k;
    key_valid = 1'b1;
    n = 0;
    while (key_ready !== 1'b1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    busy = -1;
    if (n >= LIMIT) begin
      n_cmp++; n_err++;
      key_valid = 1'b0;
      $display("FAIL send_key accept timeout: key %02h", k);
      return;
    end
    @(negedge clk);
    key_valid = 1'b0;
    model_key(k);
    busy = 0;
    while (key_ready !== 1'b1 && busy < LIMIT) begin
      busy++;
      @(negedge clk);
    end
    if (busy >= LIMIT) begin
      n_cmp++; n_err++;
      $display("FAIL send_key ready timeout: key %02h", k);
    end
  endtask

  // Pulse reset, check reset state, return cycles until key_ready rises.
  task automatic do_reset(output int cnt);
    @(negedge clk);
    reset = 1'b0;
    key_valid = 1'b0;
    #1;
    n_cmp++;
    if (key_ready !== 1'b0 || cur_x !== '0 || cur_y !== '0) begin
      n_err++;
      $display("FAIL reset_state: key_ready=%b cur=(%0d,%0d) want 0 (0,0)",
               key_ready, cur_x, cur_y);
    end
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    cnt = 0;
    while (key_ready !== 1'b1 && cnt < LIMIT) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(32, 126));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int cnt;
    do_reset(cnt);
    n_cmp++;
    if (cnt != COLS * ROWS) begin
      n_err++;
      $display("FAIL clr_all_len: got %0d cycles want %0d", cnt, COLS * ROWS);
    end
    check_cursor("reset", 0, 0);
    check_screen("reset");
  endtask

  task automatic test_basic();
    int b;
    logic [7:0] v;
    send_key(8'h41, b);
    send_key(8'h42, b);
    read_cell(0, 0, v);
    n_cmp++;
    if (v !== 8'h41) begin n_err++; $display("FAIL basic_a: got %02h want 41", v); end
    read_cell(1, 0, v);
    n_cmp++;
    if (v !== 8'h42) begin n_err++; $display("FAIL basic_b: got %02h want 42", v); end
    check_cursor("basic_ab", 2, 0);
    send_key(8'd10, b);
    check_cursor("basic_enter", 0, 1);
    check_screen("basic");
  endtask

  task automatic test_wrap();
    int b, cnt;
    logic [7:0] v;
    do_reset(cnt);
    for (int i = 0; i < COLS; i++) send_key(8'h78, b);
    check_cursor("wrap", 0, 1);
    read_cell(COLS - 1, 0, v);
    n_cmp++;
    if (v !== 8'h78) begin n_err++; $display("FAIL wrap_last: got %02h want 78", v); end
    send_key(8'd8, b);
    check_cursor("bs_up", COLS - 1, 0);
    read_cell(COLS - 1, 0, v);
    n_cmp++;
    if (v !== 8'h00) begin n_err++; $display("FAIL bs_up_clear: got %02h want 00", v); end
    for (int i = 0; i < COLS - 1; i++) send_key(8'd8, b);
    check_cursor("bs_home", 0, 0);
    send_key(8'd8, b);
    check_cursor("bs_origin", 0, 0);
    check_screen("wrap");
  endtask

  task automatic test_scroll();
    int b, cnt;
    logic [7:0] txt [6];
    logic [7:0] v;
    int bad;
    do_reset(cnt);
    send_key(8'd10, b);
    for (int i = 0; i < 6; i++) begin
      txt[i] = rand_print();
      send_key(txt[i], b);
    end
    while (my < ROWS - 1) begin
      send_key(8'd10, b);
      n_cmp++;
      if (b != 0) begin n_err++; $display("FAIL enter_busy: got %0d want 0", b); end
    end
    send_key(8'd10, b);
    n_cmp++;
    if (b != COLS) begin n_err++; $display("FAIL scroll_busy: got %0d want %0d", b, COLS); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      read_cell(i, 0, v);
      if (v !== txt[i]) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL scroll_text: %0d chars wrong on top row", bad); end
    check_cursor("scroll", 0, ROWS - 1);
    check_screen("scroll");
  endtask

  task automatic test_hold_and_reset();
    int n, cnt;
    // Scroll with the next key already held valid during the row clear.
    @(negedge clk);
    key_in = 8'd10;
    key_valid = 1'b1;
    @(negedge clk);
    model_key(8'd10);
    key_in = 8'h51;
    n = 0;
    while (key_ready !== 1'b1 && n < LIMIT) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n != COLS) begin n_err++; $display("FAIL hold_busy: got %0d want %0d", n, COLS); end
    @(negedge clk);
    key_valid = 1'b0;
    model_key(8'h51);
    repeat (3) @(negedge clk);
    check_cursor("hold_once", 1, ROWS - 1);
    check_screen("hold");
    // Start another scroll and reset in the middle of the row clear.
    send_key(8'd10, n);
    send_key(8'h52, n);
    @(negedge clk);
    key_in = 8'd10;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (10) @(negedge clk);
    do_reset(cnt);
    n_cmp++;
    if (cnt != COLS * ROWS) begin
      n_err++;
      $display("FAIL mid_reset_len: got %0d cycles want %0d", cnt, COLS * ROWS);
    end
    check_cursor("mid_reset", 0, 0);
    check_screen("mid_reset");
  endtask

  task automatic test_random();
    int b, r;
    logic [7:0] k;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12) k = 8'd10;
      else if (r < 27) k = 8'd8;
      else k = rand_print();
      send_key(k, b);
      check_cursor("random", mx, my);
      if (i % 100 == 99) check_screen("random");
    end
  endtask

  task automatic test_row();
    int vv, yy;
    logic [3:0] exp;
    y = YW'(2);
    v_addr = VADDR_W'(37);
    #1;
    n_cmp++;
    if (row !== 4'd5) begin n_err++; $display("FAIL row_37: got %0d want 5", row); end
    for (int i = 0; i < 8; i++) begin
      yy = $urandom_range(0, ROWS - 1);
      vv = yy * FONT_H + $urandom_range(0, FONT_H - 1);
      y = YW'(yy);
      v_addr = VADDR_W'(vv);
      #1;
      exp = 4'((vv - yy * FONT_H) % FONT_H);
      n_cmp++;
      if (row !== exp) begin
        n_err++;
        $display("FAIL row_rand: v=%0d y=%0d got %0d want %0d", vv, yy, row, exp);
      end
    end
  endtask

  task automatic test_blink();
    int b, cnt, bad;
    logic [7:0] s [16];
    do_reset(cnt);
    send_key(8'd10, b);
    send_key(8'd10, b);
    send_key(8'h61, b);
    send_key(8'h62, b);
    send_key(8'h63, b);
    check_cursor("blink_pos", 3, 2);
    x = XW'(3);
    y = YW'(2);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      s[i] = ascii_out;
    end
    bad = 0;
`ifdef CURSOR_BLINK_EN
    for (int i = 0; i < 16; i++) if (s[i] !== 8'h00 && s[i] !== 8'h5F) bad++;
    for (int i = 0; i < 12; i++) if (s[i+4] === s[i]) bad++;
    for (int i = 0; i < 8; i++) if (s[i+8] !== s[i]) bad++;
`else
    for (int i = 0; i < 16; i++) if (s[i] !== scr[2][3]) bad++;
`endif
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL blink_cursor: %0d bad samples, first %02h %02h %02h %02h %02h",
               bad, s[0], s[1], s[2], s[3], s[4]);
    end
    x = XW'(2);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (ascii_out !== 8'h63) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL blink_neighbour: %0d samples not 63", bad); end
  endtask

  initial begin
    reset = 1'b0;
    key_in = 8'h00;
    key_valid = 1'b0;
    x = '0;
    y = '0;
    v_addr = '0;
    model_clear();
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_scroll();
    test_hold_and_reset();
    test_random();
    test_row();
    test_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
